dot_score_unit: RTL and testbench

DOT_SCORE_UNIT -- requirements
Module: dot_score_unit

---
 rtl/dot_score_unit.sv | 169 ++++++++++++++++
 tb/tb_dot_score_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_score_unit.sv
// Dot score unit: on each synchronized frame tick, scans a snapshot of the eaten
// flags one dot per cycle, awards BCD points for newly eaten dots and counts survivors.
module dot_score_unit #(
   parameter int unsigned NUM_DOTS = 32
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [31:0] eaten,
   output logic [15:0] score,
   output logic [5:0]  dots_remaining,
   output logic        eat_pulse,
   output logic        level_clear,
   output logic        busy
);

   localparam int unsigned IDX_W = 5;
   localparam int unsigned CNT_W = 6;
   localparam logic [15:0] SCORE_MAX = 16'h9990;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOTS - 1);
   localparam logic [32:0] MASK_WIDE = (33'd1 << NUM_DOTS) - 33'd1;
   localparam logic [31:0] DOT_MASK  = MASK_WIDE[31:0];

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_UPDATE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        sync_q, sync_d;
   logic [31:0]       snap_q, snap_d;
   logic [31:0]       prev_q, prev_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              new_eat_q, new_eat_d;
   logic [15:0]       score_q, score_d;
   logic [CNT_W-1:0]  dots_q, dots_d;
   logic              eat_pulse_q, eat_pulse_d;
   logic              rise_c;
   logic              eat_now_c;
   logic              busy_c;

   // Tens-digit BCD increment with ripple into hundreds/thousands, pinned at 9990.
   function automatic logic [15:0] bcd_add10(input logic [15:0] s);
      logic [3:0]  t, h, k;
      logic [15:0] r;
      t = s[7:4];
      h = s[11:8];
      k = s[15:12];
      if (s == SCORE_MAX) begin
         r = s;
      end else begin
         if (t != 4'd9) begin
            t = t + 4'd1;
         end else begin
            t = 4'd0;
            if (h != 4'd9) begin
               h = h + 4'd1;
            end else begin
               h = 4'd0;
               k = k + 4'd1;
            end
         end
         r = {k, h, t, s[3:0]};
      end
      return r;
   endfunction

   assign sync_d = {sync_q[1:0], frame_clk};
   assign rise_c = sync_q[1] & ~sync_q[2];

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; ticks arriving outside IDLE are simply dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (rise_c) state_d = ST_SCAN;
         ST_SCAN:   if (idx_q == LAST_IDX) state_d = ST_UPDATE;
         ST_UPDATE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output decode of the state register
   always_comb begin
      busy_c = 1'b0;
      if (state_q != ST_IDLE) busy_c = 1'b1;
   end

   // Datapath next-state: snapshot, per-index scoring, commit in UPDATE
   always_comb begin
      snap_d      = snap_q;
      prev_d      = prev_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      new_eat_d   = new_eat_q;
      score_d     = score_q;
      dots_d      = dots_q;
      eat_pulse_d = 1'b0;
      eat_now_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise_c) begin
               snap_d    = eaten & DOT_MASK;
               idx_d     = '0;
               cnt_d     = '0;
               new_eat_d = 1'b0;
            end
         end
         ST_SCAN: begin
            eat_now_c = snap_q[idx_q] & ~prev_q[idx_q];
            if (eat_now_c) begin
               score_d   = bcd_add10(score_q);
               new_eat_d = 1'b1;
            end
            if (!snap_q[idx_q]) cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q + IDX_W'(1);
            // Pulse is registered so it is visible during the UPDATE cycle itself
            if (idx_q == LAST_IDX) eat_pulse_d = new_eat_q | eat_now_c;
         end
         ST_UPDATE: begin
            prev_d = snap_q;
            dots_d = cnt_q;
         end
         default: ;
      endcase
   end

   // Datapath registers; reset aborts any scan without committing
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync_q      <= '0;
         snap_q      <= '0;
         prev_q      <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         new_eat_q   <= 1'b0;
         score_q     <= '0;
         dots_q      <= CNT_W'(NUM_DOTS);
         eat_pulse_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         snap_q      <= snap_d;
         prev_q      <= prev_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         new_eat_q   <= new_eat_d;
         score_q     <= score_d;
         dots_q      <= dots_d;
         eat_pulse_q <= eat_pulse_d;
      end
   end

   assign score          = score_q;
   assign dots_remaining = dots_q;
   assign eat_pulse      = eat_pulse_q;
   assign busy           = busy_c;
   assign level_clear    = (dots_q == '0);

endmodule

// File: tb/tb_dot_score_unit.sv
// Directed bench for dot_score_unit with an arithmetic reference model of score and dot count.
module tb_dot_score_unit;

   localparam int N = 32;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_clk;
   logic [31:0] eaten;
   logic [15:0] score;
   logic [5:0]  dots_remaining;
   logic        eat_pulse;
   logic        level_clear;
   logic        busy;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [31:0] m_prev;
   int          m_pts;
   int          m_dots;

   dot_score_unit #(.NUM_DOTS(N)) dut (
      .Clk(Clk),
      .Reset(Reset),
      .frame_clk(frame_clk),
      .eaten(eaten),
      .score(score),
      .dots_remaining(dots_remaining),
      .eat_pulse(eat_pulse),
      .level_clear(level_clear),
      .busy(busy)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int p);
      return {4'(p / 1000), 4'((p / 100) % 10), 4'((p / 10) % 10), 4'(p % 10)};
   endfunction

   task automatic model_reset();
      m_prev = '0;
      m_pts  = 0;
      m_dots = N;
   endtask

   // Reference: score in plain decimal points, 10 per newly eaten dot, capped at 9990
   task automatic model_frame(input logic [31:0] snap, output bit newe);
      int u;
      newe = 1'b0;
      u    = 0;
      for (int i = 0; i < N; i++) begin
         if (snap[i] && !m_prev[i]) begin
            newe  = 1'b1;
            m_pts = (m_pts + 10 > 9990) ? 9990 : m_pts + 10;
         end
         if (!snap[i]) u++;
      end
      m_prev = snap;
      m_dots = u;
   endtask

   // Idle-time comparison against the model on every cycle
   always @(negedge Clk) begin
      if (mon_en) begin
         check("idle_score", 32'(score), 32'(to_bcd(m_pts)));
         check("idle_dots", 32'(dots_remaining), 32'(m_dots));
         check("idle_level_clear", 32'(level_clear), 32'(m_dots == 0));
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_eat_pulse", 32'(eat_pulse), 32'd0);
      end
   end

   task automatic do_reset();
      @(negedge Clk);
      mon_en = 1'b0;
      Reset  = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      mon_en = 1'b1;
   endtask

   task automatic run_frame(input bit mid_toggle, input int abort_at);
      logic [31:0] snap;
      bit newe;
      bit aborted;
      int lat, bc, pc;
      @(negedge Clk);
      mon_en    = 1'b0;
      snap      = eaten;
      frame_clk = 1'b1;
      lat = 0;
      do begin
         @(negedge Clk);
         lat++;
         if (lat == 2) frame_clk = 1'b0;
      end while (!busy && lat < 10);
      frame_clk = 1'b0;
      check("rise_to_scan_latency", 32'(lat), 32'd3);
      bc = 0;
      pc = 0;
      aborted = 1'b0;
      while (busy && bc < 100) begin
         bc++;
         if (eat_pulse) pc++;
         if (mid_toggle && bc == 10) begin
            eaten[5]  = ~eaten[5];
            frame_clk = 1'b1;
         end
         if (mid_toggle && bc == 12) frame_clk = 1'b0;
         if (abort_at >= 0 && bc == abort_at + 1) begin
            Reset   = 1'b1;
            aborted = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      if (aborted) begin
         repeat (2) @(negedge Clk);
         check("abort_score", 32'(score), 32'h0000);
         check("abort_dots", 32'(dots_remaining), 32'd32);
         check("abort_busy", 32'(busy), 32'd0);
         check("abort_eat_pulse", 32'(eat_pulse), 32'd0);
         Reset = 1'b0;
         model_reset();
      end else begin
         model_frame(snap, newe);
         check("busy_cycles", 32'(bc), 32'(N + 1));
         check("eat_pulse_cycles", 32'(pc), 32'(newe));
      end
      mon_en = 1'b1;
   endtask

   initial begin
      Reset     = 1'b1;
      frame_clk = 1'b0;
      eaten     = '0;
      model_reset();
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("reset_score", 32'(score), 32'h0000);
      check("reset_dots", 32'(dots_remaining), 32'd32);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_eat_pulse", 32'(eat_pulse), 32'd0);
      check("reset_level_clear", 32'(level_clear), 32'd0);
      mon_en = 1'b1;

      // Basic eat and no double counting
      eaten = 32'h0000_0001;
      run_frame(1'b0, -1);
      check("basic_score", 32'(score), 32'h0010);
      check("basic_dots", 32'(dots_remaining), 32'd31);
      repeat (3) run_frame(1'b0, -1);
      check("no_double_score", 32'(score), 32'h0010);

      // Level clear, then all dots restored
      do_reset();
      eaten = 32'hFFFF_FFFF;
      run_frame(1'b0, -1);
      check("clear_score", 32'(score), 32'h0320);
      check("clear_dots", 32'(dots_remaining), 32'd0);
      check("clear_flag", 32'(level_clear), 32'd1);
      eaten = 32'h0;
      run_frame(1'b0, -1);
      check("restore_dots", 32'(dots_remaining), 32'd32);
      check("restore_flag", 32'(level_clear), 32'd0);
      check("restore_score", 32'(score), 32'h0320);

      // Saturation: 31 full eat/restore rounds plus 6 dots reaches 9980
      do_reset();
      for (int r = 0; r < 31; r++) begin
         eaten = 32'hFFFF_FFFF;
         run_frame(1'b0, -1);
         eaten = 32'h0;
         run_frame(1'b0, -1);
      end
      eaten = 32'h0000_003F;
      run_frame(1'b0, -1);
      check("preload_score", 32'(score), 32'h9980);
      eaten = 32'h0000_00FF;
      run_frame(1'b0, -1);
      check("sat_score", 32'(score), 32'h9990);
      eaten = 32'h0;
      run_frame(1'b0, -1);
      eaten = 32'hFFFF_FFFF;
      run_frame(1'b0, -1);
      check("sat_hold_score", 32'(score), 32'h9990);

      // Mid-scan input change and a second tick during SCAN
      do_reset();
      eaten = 32'h0000_00F0;
      run_frame(1'b1, -1);
      check("snapshot_score", 32'(score), 32'h0040);
      check("snapshot_dots", 32'(dots_remaining), 32'd28);
      run_frame(1'b0, -1);
      check("after_toggle_score", 32'(score), 32'h0040);
      check("after_toggle_dots", 32'(dots_remaining), 32'd29);

      // Reset at index 16 with four eats already scored
      do_reset();
      eaten = 32'h0000_000F;
      run_frame(1'b0, 16);
      run_frame(1'b0, -1);
      check("post_abort_score", 32'(score), 32'h0040);
      check("post_abort_dots", 32'(dots_remaining), 32'd28);

      repeat (4) @(negedge Clk);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
